// File: rtl/life_ctrl.sv
// Game-of-Life sequencer: gates board rotation (one X*Y-cycle scan per generation),
// and handles run/pause, single-step, cursor movement and cell-flip strobes.
module life_ctrl #(
  parameter int X        = 8,
  parameter int Y        = 8,
  parameter int LOG2X    = 3,
  parameter int LOG2Y    = 3,
  parameter int RATE_DIV = 1000000,
  parameter int GEN_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_run,
  input  logic                   key_step,
  input  logic                   key_flip,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   key_up,
  input  logic                   key_down,
  output logic                   shift_en,
  output logic [LOG2X+LOG2Y-1:0] cell_index,
  output logic                   flip_pulse,
  output logic [LOG2X-1:0]       cursor_x,
  output logic [LOG2Y-1:0]       cursor_y,
  output logic                   running,
  output logic                   busy,
  output logic [GEN_W-1:0]       gen_count
);

  localparam int CW = LOG2X + LOG2Y;
  localparam int RW = $clog2(RATE_DIV + 1);
  localparam logic [CW-1:0]    LAST_CELL = CW'(X * Y - 1);
  localparam logic [RW-1:0]    RELOAD    = RW'(RATE_DIV - 1);
  localparam logic [LOG2X-1:0] X_MAX     = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX     = LOG2Y'(Y - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN} state_t;

  state_t            state;
  logic [6:0]        hist;
  logic [6:0]        keys;
  logic [6:0]        press;
  logic              flip_rel;
  logic              step_pend;
  logic              flip_pend;
  logic [RW-1:0]     rate_cnt;
  logic              run_next;
  logic              pend;
  logic              last;
  logic              fire;
  logic [LOG2X-1:0]  x_next;
  logic [LOG2Y-1:0]  y_next;

  assign keys     = {key_down, key_up, key_right, key_left, key_flip, key_step, key_run};
  assign press    = keys & ~hist;
  assign flip_rel = hist[2] & ~key_flip;
  assign run_next = running ^ press[0];
  assign pend     = flip_pend | flip_rel;
  assign last     = (state == SCAN) && (cell_index == LAST_CELL);
  // Pulse may only land on a non-shifting cycle; the last scan cycle qualifies
  // because the registered pulse appears on the first post-scan cycle.
  assign fire     = pend && ((state != SCAN) || last);

  always_comb begin
    x_next = cursor_x;
    y_next = cursor_y;
    if (press[3] && !press[4])
      x_next = (cursor_x == '0) ? X_MAX : cursor_x - LOG2X'(1);
    else if (press[4] && !press[3])
      x_next = (cursor_x == X_MAX) ? '0 : cursor_x + LOG2X'(1);
    if (press[5] && !press[6])
      y_next = (cursor_y == '0) ? Y_MAX : cursor_y - LOG2Y'(1);
    else if (press[6] && !press[5])
      y_next = (cursor_y == Y_MAX) ? '0 : cursor_y + LOG2Y'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hist       <= '0;
      step_pend  <= 1'b0;
      flip_pend  <= 1'b0;
      rate_cnt   <= '0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      cell_index <= '0;
      flip_pulse <= 1'b0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      running    <= 1'b0;
      gen_count  <= '0;
    end else begin
      hist       <= keys;
      running    <= run_next;
      flip_pulse <= fire;
      flip_pend  <= pend & ~fire;
      cursor_x   <= x_next;
      cursor_y   <= y_next;
      case (state)
        IDLE: begin
          if (step_pend && !fire) begin
            state      <= SCAN;
            step_pend  <= 1'b0;
            shift_en   <= 1'b1;
            busy       <= 1'b1;
            cell_index <= '0;
          end else begin
            if (press[1]) step_pend <= 1'b1;
            if (run_next) begin
              state    <= WAIT;
              rate_cnt <= RELOAD;
            end
          end
        end
        WAIT: begin
          if (!run_next) begin
            state <= IDLE;
          end else if (rate_cnt == '0) begin
            if (!fire) begin
              state      <= SCAN;
              step_pend  <= 1'b0;
              shift_en   <= 1'b1;
              busy       <= 1'b1;
              cell_index <= '0;
            end
          end else begin
            rate_cnt <= rate_cnt - RW'(1);
          end
        end
        SCAN: begin
          if (last) begin
            gen_count  <= gen_count + GEN_W'(1);
            shift_en   <= 1'b0;
            busy       <= 1'b0;
            cell_index <= '0;
            if (run_next) begin
              state    <= WAIT;
              rate_cnt <= RELOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cell_index <= cell_index + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: directed scenarios plus random key activity, every cycle
// compared against a cycle-level reference model of the sequencer rules.
module tb_life_ctrl;
  localparam int X = 6, Y = 5, LOG2X = 3, LOG2Y = 3, RATE_DIV = 4, GEN_W = 4;
  localparam int N = X * Y;

  localparam logic [6:0] K_RUN = 7'b0000001, K_STEP = 7'b0000010, K_FLIP = 7'b0000100;
  localparam logic [6:0] K_LEFT = 7'b0001000, K_RIGHT = 7'b0010000, K_UP = 7'b0100000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] keys = '0;
  logic shift_en, flip_pulse, running, busy;
  logic [LOG2X+LOG2Y-1:0] cell_index;
  logic [LOG2X-1:0] cursor_x;
  logic [LOG2Y-1:0] cursor_y;
  logic [GEN_W-1:0] gen_count;

  life_ctrl #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y), .RATE_DIV(RATE_DIV), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset),
    .key_run(keys[0]), .key_step(keys[1]), .key_flip(keys[2]), .key_left(keys[3]),
    .key_right(keys[4]), .key_up(keys[5]), .key_down(keys[6]),
    .shift_en(shift_en), .cell_index(cell_index), .flip_pulse(flip_pulse),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .running(running), .busy(busy),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // Reference model: m_scan is the scan position (-1 when not scanning),
  // m_wait the remaining rate count (-1 when paused).
  int m_scan, m_wait, m_gen, m_cx, m_cy;
  bit m_run, m_sp, m_fp, m_pulse;
  logic [6:0] m_prev;

  int n_cmp = 0, n_err = 0;
  int run_len = 0, last_len = 0, pulses = 0, overlap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = -1; m_wait = -1; m_gen = 0; m_cx = 0; m_cy = 0;
    m_run = 0; m_sp = 0; m_fp = 0; m_pulse = 0; m_prev = '0;
  endtask

  task automatic model_step(input logic [6:0] k);
    logic [6:0] pr;
    bit rel, run_n, pend, fire, scanning, last;
    int dx, dy;
    pr = k & ~m_prev;
    rel = m_prev[2] & ~k[2];
    m_prev = k;
    run_n = m_run ^ pr[0];
    scanning = (m_scan >= 0);
    last = (m_scan == N - 1);
    pend = m_fp | rel;
    fire = pend && (!scanning || last);
    m_pulse = fire;
    m_fp = pend && !fire;
    dx = int'(pr[4]) - int'(pr[3]);
    dy = int'(pr[6]) - int'(pr[5]);
    m_cx = (m_cx + dx + X) % X;
    m_cy = (m_cy + dy + Y) % Y;
    if (scanning) begin
      if (last) begin
        m_gen = (m_gen + 1) % (1 << GEN_W);
        m_scan = -1;
        m_wait = run_n ? RATE_DIV - 1 : -1;
      end else m_scan++;
    end else if (m_wait >= 0) begin
      if (!run_n) m_wait = -1;
      else if (m_wait == 0) begin
        if (!fire) begin m_scan = 0; m_wait = -1; m_sp = 0; end
      end else m_wait--;
    end else begin
      if (m_sp && !fire) begin m_scan = 0; m_sp = 0; end
      else begin
        m_sp = m_sp | pr[1];
        if (run_n) m_wait = RATE_DIV - 1;
      end
    end
    m_run = run_n;
  endtask

  task automatic check_outputs();
    check("shift_en", shift_en, m_scan >= 0);
    check("busy", busy, m_scan >= 0);
    check("cell_index", cell_index, (m_scan >= 0) ? m_scan : 0);
    check("flip_pulse", flip_pulse, m_pulse);
    check("cursor_x", cursor_x, m_cx);
    check("cursor_y", cursor_y, m_cy);
    check("running", running, m_run);
    check("gen_count", gen_count, m_gen);
  endtask

  // One clock: observe outputs away from the edge, then drive keys for the next edge.
  task automatic cycle(input logic [6:0] k);
    @(negedge clk);
    check_outputs();
    if (shift_en === 1'b1) run_len++;
    else begin
      if (run_len > 0) last_len = run_len;
      run_len = 0;
    end
    if (flip_pulse === 1'b1) pulses++;
    if (flip_pulse === 1'b1 && shift_en === 1'b1) overlap++;
    keys = k;
    model_step(k);
  endtask

  task automatic apply_reset(input logic [6:0] hold);
    @(posedge clk);
    #2 reset = 1'b1;
    keys = hold;
    #1;
    check("rst_shift_en", shift_en, 0);
    check("rst_cell_index", cell_index, 0);
    check("rst_flip_pulse", flip_pulse, 0);
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
    check("rst_running", running, 0);
    check("rst_busy", busy, 0);
    check("rst_gen_count", gen_count, 0);
    model_reset();
    run_len = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_step(hold);
  endtask

  task automatic run_until_gen(input int target, input int budget);
    int n = 0;
    while (gen_count !== GEN_W'(target) && n < budget) begin
      cycle('0);
      n++;
    end
    check("gen_reach", gen_count, target);
  endtask

  task automatic wait_scan_at(input int idx);
    int n = 0;
    while (!(busy === 1'b1 && cell_index == idx) && n < 200) begin
      cycle('0);
      n++;
    end
    check("scan_at", cell_index, idx);
  endtask

  initial begin
    int p0;
    logic [6:0] k;
    model_reset();

    // Step key held through reset release counts as a press: one generation.
    apply_reset(K_STEP);
    run_until_gen(1, N + 10);
    repeat (3) cycle('0);
    check("scan_len_step", last_len, N);
    check("running_after_step", running, 0);

    // Cursor wrap-around and opposite-key cancellation.
    cycle(K_LEFT); cycle('0); cycle(K_UP); cycle('0);
    check("cur_wrap_x", cursor_x, X - 1);
    check("cur_wrap_y", cursor_y, Y - 1);
    cycle(K_RIGHT); cycle('0);
    check("cur_right_wrap", cursor_x, 0);
    cycle(K_LEFT | K_RIGHT); cycle('0);
    check("cur_cancel", cursor_x, 0);

    // Run mode: three generations, then pause requested mid-scan.
    cycle(K_RUN); cycle('0);
    run_until_gen(4, 3 * (N + RATE_DIV) + 10);
    check("scan_len_run", last_len, N);
    wait_scan_at(10);
    cycle(K_RUN); cycle('0);
    repeat (N + RATE_DIV + 5) cycle('0);
    check("paused_running", running, 0);
    check("paused_busy", busy, 0);
    check("gen_after_pause", gen_count, 5);

    // Flip released mid-scan: deferred, exactly one pulse, never during shifting.
    cycle(K_STEP); cycle('0);
    wait_scan_at(8);
    p0 = pulses;
    cycle(K_FLIP); cycle(K_FLIP); cycle('0);
    repeat (N + 5) cycle('0);
    check("flip_pulses", pulses - p0, 1);
    check("flip_overlap", overlap, 0);

    // Reset in the middle of a scan aborts it without counting a generation.
    apply_reset('0);
    cycle(K_STEP); cycle('0);
    wait_scan_at(20);
    apply_reset('0);
    repeat (5) cycle('0);
    check("gen_after_abort", gen_count, 0);

    // Generation counter wraps modulo 2**GEN_W.
    for (int i = 1; i <= 16; i++) begin
      cycle(K_STEP); cycle('0);
      run_until_gen(i % 16, N + 10);
    end

    // Random key activity against the model.
    for (int c = 0; c < 3000; c++) begin
      k = keys;
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, (b == 0) ? 39 : 7) == 0) k[b] = ~k[b];
      cycle(k);
    end
    repeat (N + 10) cycle('0);
    check("flip_overlap_final", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
